// File: rtl/pwm_led_bank.sv
// pwm_led_bank: multi-channel static/breathe PWM LED driver sharing one period counter.
// Define PWM_LED_GAMMA_EN to add a registered gamma curve on the compare value.
module pwm_led_bank #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 48,
    parameter int FADE_DIV = 64,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic                wr_mode,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);

    logic [PW-1:0]                   presc_q, presc_d;
    logic [WIDTH-1:0]                cnt_q, cnt_d;
    logic [FW-1:0]                   fade_q, fade_d;
    logic                            pending_q, pending_d;
    logic [CW-1:0]                   chan_q, chan_d;
    logic                            pmode_q, pmode_d;
    logic [WIDTH-1:0]                duty_q, duty_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  level_q, level_d, target_q, target_d;
    logic [CHANNELS-1:0]             mode_q, mode_d, dir_q, dir_d;
    logic [CHANNELS-1:0]             pwm_out_q, pwm_out_d;
    logic                            period_start_q, period_start_d;
    logic                            tick, boundary, fade_step;
`ifdef PWM_LED_GAMMA_EN
    logic [CHANNELS-1:0][WIDTH-1:0]  cmp_q, cmp_d;
    logic                            ps1_q;

    function automatic logic [WIDTH-1:0] cmp_fn(input logic [WIDTH-1:0] l);
        logic [2*WIDTH-1:0] w;
        w = {{WIDTH{1'b0}}, l};
        w = w * w + w;
        return w[2*WIDTH-1:WIDTH];
    endfunction
`endif

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

    always_comb begin
        tick      = presc_q == PW'(TICK_DIV - 1);
        boundary  = tick && cnt_q == CNT_LAST;
        fade_step = boundary && fade_q == FW'(FADE_DIV - 1);
        presc_d   = tick ? '0 : presc_q + PW'(1);
        cnt_d     = boundary ? '0 : cnt_q + WIDTH'(tick);
        fade_d    = fade_step ? '0 : fade_q + FW'(boundary);
        wr_ready  = !pending_q && !rst;
        pending_d = pending_q && !boundary;
        chan_d    = chan_q;
        pmode_d   = pmode_q;
        duty_d    = duty_q;
        if (wr_valid && wr_ready) begin
            pending_d = 1'b1;
            chan_d    = wr_chan;
            pmode_d   = wr_mode;
            duty_d    = wr_duty;
        end
        level_d   = level_q;
        target_d  = target_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        pwm_out_d = '0;
`ifdef PWM_LED_GAMMA_EN
        cmp_d          = '0;
        period_start_d = ps1_q;
`else
        period_start_d = boundary;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            // a drained write wins over a fade step landing on the same boundary
            if (boundary && pending_q && chan_q == CW'(i)) begin
                level_d[i]  = pmode_q ? '0 : duty_q;
                target_d[i] = duty_q;
                mode_d[i]   = pmode_q;
                dir_d[i]    = 1'b0;
            end else if (fade_step && mode_q[i]) begin
                if (!dir_q[i] && level_q[i] < target_q[i])
                    level_d[i] = level_q[i] + WIDTH'(1);
                else if (dir_q[i] && level_q[i] != '0)
                    level_d[i] = level_q[i] - WIDTH'(1);
                else
                    dir_d[i] = !dir_q[i];
            end
`ifdef PWM_LED_GAMMA_EN
            cmp_d[i]     = cmp_fn(level_d[i]);
            pwm_out_d[i] = cnt_q < cmp_q[i];
`else
            pwm_out_d[i] = cnt_d < level_d[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            fade_q         <= '0;
            pending_q      <= 1'b0;
            chan_q         <= '0;
            pmode_q        <= 1'b0;
            duty_q         <= '0;
            level_q        <= '0;
            target_q       <= '0;
            mode_q         <= '0;
            dir_q          <= '0;
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
`ifdef PWM_LED_GAMMA_EN
            cmp_q          <= '0;
            ps1_q          <= 1'b0;
`endif
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            fade_q         <= fade_d;
            pending_q      <= pending_d;
            chan_q         <= chan_d;
            pmode_q        <= pmode_d;
            duty_q         <= duty_d;
            level_q        <= level_d;
            target_q       <= target_d;
            mode_q         <= mode_d;
            dir_q          <= dir_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
`ifdef PWM_LED_GAMMA_EN
            cmp_q          <= cmp_d;
            ps1_q          <= boundary;
`endif
        end
    end
endmodule
